// File: rtl/fx_slave.sv
// fx_slave: responder on the fx bus.
//
// Decodes fx write/read strobes whose address bits [21:16] match DEV_ID and
// serves a small local map:
//   0x0000-0x000F  RW configuration bytes (exported on cfg_regs)
//   0x0010         STATUS {4'b0, udf, ovf, full, empty}; bits 2/3 are W1C
//   0x0011         LEVEL, zero-extended FIFO count
//   0x0020         FIFO data; a read pops, a write is ignored
//   0x0030         CMD, write only; raises cmd_pulse for one cycle
// Everything else reads 0 and ignores writes.
//
// Ports:
//   clk_sys              system clock, rising edge
//   rst                  asynchronous active-high reset
//   fx_waddr/fx_wr/fx_data   write address, strobe and data
//   fx_raddr/fx_rd           read address and strobe
//   fx_q                 registered read data, 1-cycle latency, 0 when idle
//   cfg_regs             16 config bytes, byte n at [8n+7:8n]
//   cmd_pulse/cmd_data   one-cycle command strobe and last command byte
//   dev_data/dev_vld     device-side FIFO push
//   dev_full             FIFO full (combinational from the count)
//
// Optional build macro FX_SLAVE_RDCLR_EN: a STATUS read hit also clears the
// sticky ovf/udf flags (the read still returns the pre-clear value).

module fx_slave #(
  parameter logic [5:0]  DEV_ID  = 6'h01,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic [21:0]  fx_waddr,
  input  logic         fx_wr,
  input  logic [7:0]   fx_data,
  input  logic [21:0]  fx_raddr,
  input  logic         fx_rd,
  output logic [7:0]   fx_q,
  output logic [127:0] cfg_regs,
  output logic         cmd_pulse,
  output logic [7:0]   cmd_data,
  input  logic [7:0]   dev_data,
  input  logic         dev_vld,
  output logic         dev_full
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  localparam logic [FIFO_AW:0]   FullCnt = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CntOne  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PtrOne  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  localparam logic [15:0] AddrStatus = 16'h0010;
  localparam logic [15:0] AddrLevel  = 16'h0011;
  localparam logic [15:0] AddrFifo   = 16'h0020;
  localparam logic [15:0] AddrCmd    = 16'h0030;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]         cfg_q [16];
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               cmd_pulse_q, cmd_pulse_d;
  logic [7:0]         cmd_data_q, cmd_data_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic        wr_hit, rd_hit;
  logic [15:0] wloc, rloc;
  logic        wr_cfg, wr_stat, wr_cmd;
  logic        rd_cfg, rd_stat, rd_fifo;

  assign wloc   = fx_waddr[15:0];
  assign rloc   = fx_raddr[15:0];
  assign wr_hit = fx_wr && (fx_waddr[21:16] == DEV_ID);
  assign rd_hit = fx_rd && (fx_raddr[21:16] == DEV_ID);

  assign wr_cfg  = wr_hit && (wloc[15:4] == 12'h000);
  assign wr_stat = wr_hit && (wloc == AddrStatus);
  assign wr_cmd  = wr_hit && (wloc == AddrCmd);

  assign rd_cfg  = rd_hit && (rloc[15:4] == 12'h000);
  assign rd_stat = rd_hit && (rloc == AddrStatus);
  assign rd_fifo = rd_hit && (rloc == AddrFifo);

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic empty, full;
  logic pop, push;
  logic ovf_set, udf_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCnt);

  assign pop     = rd_fifo && !empty;
  assign udf_set = rd_fifo && empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO lands.
  assign push    = dev_vld && (!full || pop);
  assign ovf_set = dev_vld && full && !pop;

  assign dev_full = full;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PtrOne;
    end
    if (pop) begin
      rptr_d = rptr_q + PtrOne;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: clear first, then set, so a same-cycle set wins.
  // ---------------------------------------------------------------------------
  logic ovf_clr, udf_clr;

`ifdef FX_SLAVE_RDCLR_EN
  assign ovf_clr = (wr_stat && fx_data[2]) || rd_stat;
  assign udf_clr = (wr_stat && fx_data[3]) || rd_stat;
`else
  assign ovf_clr = wr_stat && fx_data[2];
  assign udf_clr = wr_stat && fx_data[3];
`endif

  always_comb begin
    ovf_d = (ovf_q && !ovf_clr) || ovf_set;
    udf_d = (udf_q && !udf_clr) || udf_set;
  end

  // ---------------------------------------------------------------------------
  // Read data: built from pre-update state, returns 0 when no read hit.
  // ---------------------------------------------------------------------------
  logic [7:0] status;

  assign status = {4'b0000, udf_q, ovf_q, full, empty};

  always_comb begin
    rdata_d = 8'h00;
    if (rd_cfg) begin
      rdata_d = cfg_q[rloc[3:0]];
    end else if (rd_hit) begin
      case (rloc)
        AddrStatus: rdata_d = status;
        AddrLevel:  rdata_d = 8'(count_q);
        AddrFifo:   rdata_d = pop ? mem_q[rptr_q] : 8'h00;
        default:    rdata_d = 8'h00;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Command port
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_pulse_d = wr_cmd;
    cmd_data_d  = wr_cmd ? fx_data : cmd_data_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        cfg_q[i] <= 8'h00;
      end
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      rdata_q     <= 8'h00;
      cmd_pulse_q <= 1'b0;
      cmd_data_q  <= 8'h00;
    end else begin
      if (wr_cfg) begin
        cfg_q[wloc[3:0]] <= fx_data;
      end
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      rdata_q     <= rdata_d;
      cmd_pulse_q <= cmd_pulse_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  // Storage is not reset: contents are only visible through count/pointers,
  // which are.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_q[wptr_q] <= dev_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 16; g++) begin : g_cfg_out
    assign cfg_regs[8*g +: 8] = cfg_q[g];
  end

  assign fx_q      = rdata_q;
  assign cmd_pulse = cmd_pulse_q;
  assign cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_fx_slave.sv
// Self-checking bench for fx_slave: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference model.

module tb_fx_slave;

  localparam logic [5:0] DEV_ID = 6'h01;
  localparam int         DEPTH  = 16;

  logic         clk_sys = 1'b0;
  logic         rst     = 1'b1;
  logic [21:0]  fx_waddr = '0;
  logic         fx_wr    = 1'b0;
  logic [7:0]   fx_data  = '0;
  logic [21:0]  fx_raddr = '0;
  logic         fx_rd    = 1'b0;
  logic [7:0]   fx_q;
  logic [127:0] cfg_regs;
  logic         cmd_pulse;
  logic [7:0]   cmd_data;
  logic [7:0]   dev_data = '0;
  logic         dev_vld  = 1'b0;
  logic         dev_full;

  fx_slave #(
    .DEV_ID  (DEV_ID),
    .FIFO_AW (4)
  ) u_dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .fx_waddr  (fx_waddr),
    .fx_wr     (fx_wr),
    .fx_data   (fx_data),
    .fx_raddr  (fx_raddr),
    .fx_rd     (fx_rd),
    .fx_q      (fx_q),
    .cfg_regs  (cfg_regs),
    .cmd_pulse (cmd_pulse),
    .cmd_data  (cmd_data),
    .dev_data  (dev_data),
    .dev_vld   (dev_vld),
    .dev_full  (dev_full)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_q_fifo [$];
  logic [7:0] m_cfg [16];
  logic       m_ovf, m_udf;
  logic [7:0] m_rdata;
  logic       m_pulse;
  logic [7:0] m_cmd;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] model_cfg();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = m_cfg[i];
    return v;
  endfunction

  task automatic model_reset();
    m_q_fifo.delete();
    for (int i = 0; i < 16; i++) m_cfg[i] = 8'h00;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rdata = 8'h00;
    m_pulse = 1'b0;
    m_cmd   = 8'h00;
  endtask

  // Applies one clock's worth of bus/device activity to the model.
  task automatic model_step(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                            input logic rd, input logic [21:0] ra,
                            input logic vld, input logic [7:0] dd);
    logic wh, rh, ovf_s, udf_s;
    int   lvl;
    wh    = wr && (wa[21:16] == DEV_ID);
    rh    = rd && (ra[21:16] == DEV_ID);
    lvl   = m_q_fifo.size();
    ovf_s = 1'b0;
    udf_s = 1'b0;
    m_rdata = 8'h00;
    if (rh) begin
      if (ra[15:0] < 16'd16)           m_rdata = m_cfg[ra[3:0]];
      else if (ra[15:0] == 16'h0010)   m_rdata = {4'b0, m_udf, m_ovf, lvl == DEPTH, lvl == 0};
      else if (ra[15:0] == 16'h0011)   m_rdata = 8'(lvl);
      else if (ra[15:0] == 16'h0020)   m_rdata = (lvl > 0) ? m_q_fifo[0] : 8'h00;
    end
    if (rh && ra[15:0] == 16'h0020) begin
      if (m_q_fifo.size() > 0) void'(m_q_fifo.pop_front());
      else udf_s = 1'b1;
    end
    if (vld) begin
      if (m_q_fifo.size() < DEPTH) m_q_fifo.push_back(dd);
      else ovf_s = 1'b1;
    end
    if (wh && wa[15:0] == 16'h0010) begin
      if (wd[2]) m_ovf = 1'b0;
      if (wd[3]) m_udf = 1'b0;
    end
`ifdef FX_SLAVE_RDCLR_EN
    if (rh && ra[15:0] == 16'h0010) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
`endif
    if (ovf_s) m_ovf = 1'b1;
    if (udf_s) m_udf = 1'b1;
    m_pulse = wh && (wa[15:0] == 16'h0030);
    if (m_pulse) m_cmd = wd;
    if (wh && wa[15:0] < 16'd16) m_cfg[wa[3:0]] = wd;
  endtask

  task automatic compare_all();
    check("fx_q", fx_q, m_rdata);
    check("cfg_regs", cfg_regs, model_cfg());
    check("cmd_pulse", cmd_pulse, m_pulse);
    check("cmd_data", cmd_data, m_cmd);
    check("dev_full", dev_full, m_q_fifo.size() == DEPTH);
  endtask

  // Drive one cycle at the falling edge, sample 1 time unit after the rise.
  task automatic step(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                      input logic rd, input logic [21:0] ra,
                      input logic vld, input logic [7:0] dd);
    @(negedge clk_sys);
    fx_wr = wr; fx_waddr = wa; fx_data = wd;
    fx_rd = rd; fx_raddr = ra;
    dev_vld = vld; dev_data = dd;
    @(posedge clk_sys);
    #1;
    model_step(wr, wa, wd, rd, ra, vld, dd);
    fx_wr = 1'b0; fx_rd = 1'b0; dev_vld = 1'b0;
    compare_all();
  endtask

  task automatic do_wr(input logic [15:0] loc, input logic [7:0] d);
    step(1'b1, {DEV_ID, loc}, d, 1'b0, 22'h0, 1'b0, 8'h00);
  endtask

  task automatic do_rd(input logic [15:0] loc);
    step(1'b0, 22'h0, 8'h00, 1'b1, {DEV_ID, loc}, 1'b0, 8'h00);
  endtask

  task automatic do_push(input logic [7:0] d);
    step(1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 1'b1, d);
  endtask

  task automatic do_idle();
    step(1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 1'b0, 8'h00);
  endtask

  function automatic logic [21:0] rnd_addr();
    logic [5:0]  id;
    logic [15:0] loc;
    id = ($urandom_range(0, 9) == 0) ? 6'($urandom) : DEV_ID;
    case ($urandom_range(0, 5))
      0, 1:    loc = 16'($urandom_range(0, 15));
      2:       loc = 16'h0010;
      3:       loc = 16'h0011;
      4:       loc = 16'h0020;
      default: loc = ($urandom_range(0, 1) == 1) ? 16'h0030 : 16'($urandom);
    endcase
    return {id, loc};
  endfunction

  initial begin
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_fx_q", fx_q, 8'h00);
    check("rst_cfg", cfg_regs, 128'h0);
    check("rst_cmd_pulse", cmd_pulse, 1'b0);
    check("rst_dev_full", dev_full, 1'b0);
    @(negedge clk_sys);
    rst = 1'b0;

    // Config write/read and idle return-to-zero
    do_wr(16'h0003, 8'h5A);
    check("cfg3_written", cfg_regs[31:24], 8'h5A);
    do_rd(16'h0003);
    check("rd_cfg3", fx_q, 8'h5A);
    do_idle();
    check("rd_idle_zero", fx_q, 8'h00);

    // Foreign device ID is ignored
    step(1'b1, {DEV_ID + 6'd1, 16'h0003}, 8'hC3, 1'b0, 22'h0, 1'b0, 8'h00);
    check("badid_wr", cfg_regs[31:24], 8'h5A);
    step(1'b0, 22'h0, 8'h00, 1'b1, {DEV_ID + 6'd1, 16'h0003}, 1'b0, 8'h00);
    check("badid_rd", fx_q, 8'h00);

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) do_push(8'h10 + 8'(i));
    do_push(8'hEE);
    check("full_flag", dev_full, 1'b1);
    do_rd(16'h0011);
    check("level_full", fx_q, 8'h10);
    do_rd(16'h0010);
    check("status_full_ovf", fx_q, 8'h06);
    for (int i = 0; i < 16; i++) begin
      do_rd(16'h0020);
      check("pop_order", fx_q, 8'h10 + 8'(i));
    end
    do_wr(16'h0010, 8'h04);

    // Underflow and W1C
    do_rd(16'h0020);
    check("pop_empty", fx_q, 8'h00);
    do_rd(16'h0010);
    check("status_udf", fx_q, 8'h09);
    do_wr(16'h0010, 8'h08);
    do_rd(16'h0010);
    check("status_w1c", fx_q, 8'h01);

    // Push and pop together while full
    for (int i = 0; i < 16; i++) do_push(8'h40 + 8'(i));
    step(1'b0, 22'h0, 8'h00, 1'b1, {DEV_ID, 16'h0020}, 1'b1, 8'h77);
    check("full_pushpop", fx_q, 8'h40);
    do_rd(16'h0011);
    check("level_pushpop", fx_q, 8'h10);
    do_rd(16'h0010);
    check("status_pushpop", fx_q, 8'h02);

    // Command strobe
    do_wr(16'h0030, 8'hA5);
    check("cmd_pulse_hi", cmd_pulse, 1'b1);
    check("cmd_data_a5", cmd_data, 8'hA5);
    do_idle();
    check("cmd_pulse_lo", cmd_pulse, 1'b0);

    // STATUS read side effect depends on build
    do_push(8'h99);
    do_rd(16'h0010);
    check("status_ovf_1", fx_q, 8'h06);
    do_rd(16'h0010);
`ifdef FX_SLAVE_RDCLR_EN
    check("status_rdclr", fx_q, 8'h02);
`else
    check("status_no_rdclr", fx_q, 8'h06);
`endif

    // Random traffic with a mid-run asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      int vld_pct;
      vld_pct = ((i / 200) % 2 == 1) ? 80 : 25;
      if (i == 700) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_fx_q", fx_q, 8'h00);
        check("midrst_cfg", cfg_regs, 128'h0);
        check("midrst_full", dev_full, 1'b0);
        @(negedge clk_sys);
        rst = 1'b0;
      end
      step($urandom_range(0, 99) < 30, rnd_addr(), 8'($urandom),
           $urandom_range(0, 99) < 45, rnd_addr(),
           $urandom_range(0, 99) < vld_pct, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
